// File: rtl/lut_neuron_readback.sv
// lut_neuron_readback
//   Sweeps every address of a LUT neuron (combinational or pipelined ROM),
//   captures each result once it is valid, packs the results LSB-first into
//   WORD_W-bit words and streams them out over valid/ready.
//
//   Optional feature, enabled by defining LUT_READBACK_CHECKSUM_EN:
//   an extra beat follows the last data word. It carries the XOR of all data
//   words in the sweep and takes over m_tlast. Without the macro no
//   accumulator exists and the stream ends on the last data word.
module lut_neuron_readback #(
  parameter int IN_BITS     = 8,
  parameter int OUT_BITS    = 1,
  parameter int WORD_W      = 32,
  parameter int LUT_LATENCY = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [IN_BITS-1:0]  lut_addr,
  input  logic [OUT_BITS-1:0] lut_data,
  output logic [WORD_W-1:0]   m_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                m_tlast
);

  // Sweep geometry. E (entries per word) always divides 2^IN_BITS, so it is a
  // power of two and the slot counter wraps naturally.
  localparam int NUM_ENTRIES      = 1 << IN_BITS;
  localparam int ENTRIES_PER_WORD = WORD_W / OUT_BITS;
  localparam int NUM_BEATS        = (NUM_ENTRIES * OUT_BITS) / WORD_W;
  localparam int SLOT_W = (ENTRIES_PER_WORD > 1) ? $clog2(ENTRIES_PER_WORD) : 1;
  localparam int BEAT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int LAT_W  = (LUT_LATENCY > 1) ? $clog2(LUT_LATENCY) : 1;

  localparam logic [IN_BITS-1:0] ENTRY_ONE = IN_BITS'(1);
  localparam logic [SLOT_W-1:0]  SLOT_ONE  = SLOT_W'(1);
  localparam logic [SLOT_W-1:0]  SLOT_LAST = SLOT_W'(ENTRIES_PER_WORD - 1);
  localparam logic [BEAT_W-1:0]  BEAT_ONE  = BEAT_W'(1);
  localparam logic [BEAT_W-1:0]  BEAT_LAST = BEAT_W'(NUM_BEATS - 1);
  localparam logic [LAT_W-1:0]   LAT_ONE   = LAT_W'(1);
  // WAIT spends LUT_LATENCY cycles after SAMPLE, counting LUT_LATENCY-1 down to 0.
  localparam logic [LAT_W-1:0]   LAT_LOAD  = (LUT_LATENCY > 0) ? LAT_W'(LUT_LATENCY - 1) : '0;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SAMPLE = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_EMIT   = 3'd3;
`ifdef LUT_READBACK_CHECKSUM_EN
  localparam logic [2:0] ST_CSUM   = 3'd4;
`endif

  logic [2:0]          state;
  logic [IN_BITS-1:0]  entry;
  logic [SLOT_W-1:0]   slot;
  logic [BEAT_W-1:0]   beat;
  logic [LAT_W-1:0]    lat_cnt;
  logic [WORD_W-1:0]   pack;

  logic start_accept;
  logic capture;
  logic handshake;
  logic last_slot;
  logic last_beat;

  // Decode of the current cycle's events from the registered state.
  // NOTE: every signal assigned in always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    start_accept = 1'b0;
    capture      = 1'b0;
    // A start coinciding with the done pulse is deliberately ignored.
    if (state == ST_IDLE && start && !done) start_accept = 1'b1;
    if (state == ST_SAMPLE && LUT_LATENCY == 0) capture = 1'b1;
    if (state == ST_WAIT && lat_cnt == '0) capture = 1'b1;
  end

  assign handshake = m_tvalid && m_tready;
  assign last_slot = (slot == SLOT_LAST);
  assign last_beat = (beat == BEAT_LAST);
  assign lut_addr  = entry;

  // Sweep FSM: address/slot/beat/latency counters plus busy and done.
  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      entry   <= '0;
      slot    <= '0;
      beat    <= '0;
      lat_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_accept) begin
            state <= ST_SAMPLE;
            busy  <= 1'b1;
            entry <= '0;
            slot  <= '0;
            beat  <= '0;
          end
        end

        ST_SAMPLE: begin
          if (LUT_LATENCY > 0) begin
            state   <= ST_WAIT;
            lat_cnt <= LAT_LOAD;
          end else if (last_slot) begin
            state <= ST_EMIT;
          end else begin
            entry <= entry + ENTRY_ONE;
            slot  <= slot + SLOT_ONE;
          end
        end

        ST_WAIT: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - LAT_ONE;
          end else if (last_slot) begin
            state <= ST_EMIT;
          end else begin
            entry <= entry + ENTRY_ONE;
            slot  <= slot + SLOT_ONE;
            state <= ST_SAMPLE;
          end
        end

        ST_EMIT: begin
          // Address, slot and beat are frozen until the word is accepted.
          if (handshake) begin
            slot <= '0;
            beat <= beat + BEAT_ONE;
            if (last_beat) begin
`ifdef LUT_READBACK_CHECKSUM_EN
              state <= ST_CSUM;
`else
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              entry <= '0;
              beat  <= '0;
`endif
            end else begin
              entry <= entry + ENTRY_ONE;
              state <= ST_SAMPLE;
            end
          end
        end

`ifdef LUT_READBACK_CHECKSUM_EN
        ST_CSUM: begin
          if (handshake) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            entry <= '0;
            beat  <= '0;
          end
        end
`endif

        default: state <= ST_IDLE;
      endcase
    end
  end

  // Pack register: insert each captured result at its slot, clear once the
  // word has been handed downstream so the next word starts from zero.
  // NOTE: this register is cleared on reset because a partial word must
  // never leak into the first word of the next sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pack <= '0;
    end else if (capture) begin
      pack[int'(slot) * OUT_BITS +: OUT_BITS] <= lut_data;
    end else if (state == ST_EMIT && handshake) begin
      pack <= '0;
    end
  end

`ifdef LUT_READBACK_CHECKSUM_EN
  logic [WORD_W-1:0] csum;

  // Checksum accumulator: XOR of every data word accepted in this sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum <= '0;
    end else if (start_accept) begin
      csum <= '0;
    end else if (state == ST_EMIT && handshake) begin
      csum <= csum ^ pack;
    end
  end

  assign m_tvalid = (state == ST_EMIT) || (state == ST_CSUM);
  assign m_tdata  = (state == ST_CSUM) ? csum : pack;
  assign m_tlast  = (state == ST_CSUM);
`else
  assign m_tvalid = (state == ST_EMIT);
  assign m_tdata  = pack;
  assign m_tlast  = (state == ST_EMIT) && last_beat;
`endif

endmodule

// File: tb/tb_lut_neuron_readback.sv
// tb_lut_neuron_readback
//   Drives two readback engines (LUT_LATENCY 0 and 2) against a truth table
//   held in the bench, and compares the stream with words built directly from
//   that table. Honours LUT_READBACK_CHECKSUM_EN for the extra checksum beat.
module tb_lut_neuron_readback;

  localparam int IN_BITS  = 8;
  localparam int OUT_BITS = 1;
  localparam int WORD_W   = 32;
  localparam int N_ENT    = 256;
  localparam int E        = WORD_W / OUT_BITS;
  localparam int N_WORDS  = N_ENT / E;
`ifdef LUT_READBACK_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int EXP_BEATS = N_WORDS + CS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst, start, m_tready, sel;

  // Truth table of the neuron under test.
  bit tt [N_ENT];

  logic [IN_BITS-1:0] addr0, addr1;
  logic               dat0, dat1, p1, p2;
  logic               busy0, busy1, done0, done1;
  logic [WORD_W-1:0]  td0, td1;
  logic               tv0, tv1, tl0, tl1;
  logic               start0, start1;

  assign dat0   = tt[addr0];
  always @(posedge clk) begin
    p1 <= tt[addr1];
    p2 <= p1;
  end
  assign dat1   = p2;
  assign start0 = start & ~sel;
  assign start1 = start & sel;

  lut_neuron_readback #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .WORD_W(WORD_W), .LUT_LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
    .lut_addr(addr0), .lut_data(dat0), .m_tdata(td0), .m_tvalid(tv0),
    .m_tready(m_tready), .m_tlast(tl0)
  );

  lut_neuron_readback #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .WORD_W(WORD_W), .LUT_LATENCY(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .lut_addr(addr1), .lut_data(dat1), .m_tdata(td1), .m_tvalid(tv1),
    .m_tready(m_tready), .m_tlast(tl1)
  );

  logic               busy, done, m_tvalid, m_tlast;
  logic [IN_BITS-1:0] lut_addr;
  logic [WORD_W-1:0]  m_tdata;
  assign busy     = sel ? busy1 : busy0;
  assign done     = sel ? done1 : done0;
  assign m_tvalid = sel ? tv1   : tv0;
  assign m_tlast  = sel ? tl1   : tl0;
  assign lut_addr = sel ? addr1 : addr0;
  assign m_tdata  = sel ? td1   : td0;

  int total  = 0;
  int passed = 0;

  logic [WORD_W-1:0] exp_q [$];

  // Reference: word w holds table entries w*E .. w*E+E-1, lowest entry in bit 0.
  task automatic build_expected();
    logic [WORD_W-1:0] w, x;
    exp_q.delete();
    x = '0;
    for (int wi = 0; wi < N_WORDS; wi++) begin
      w = '0;
      for (int j = 0; j < E; j++) w[j] = tt[wi * E + j];
      exp_q.push_back(w);
      x = x ^ w;
    end
    if (CS == 1) exp_q.push_back(x);
  endtask

  task automatic fill_alt();
    for (int i = 0; i < N_ENT; i++) tt[i] = (i % 2 == 1);
  endtask

  task automatic fill_top();
    for (int i = 0; i < N_ENT; i++) tt[i] = (i == N_ENT - 1);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N_ENT; i++) tt[i] = ($urandom_range(0, 1) == 1);
  endtask

  // One complete sweep with optional stall, random backpressure, a stray
  // start mid-sweep, or a start in the done cycle. exp_dur < 0: any finish.
  task automatic run_sweep(input string name, input int stall_beat, input int stall_len,
                           input bit rand_bp, input int extra_start_at,
                           input bit start_on_done, input int exp_dur);
    int beats, start_cyc, dur, stall_left;
    bit stalled, first, resume_chk;
    logic [WORD_W-1:0]  held_d;
    logic [IN_BITS-1:0] held_a;
    beats = 0; dur = -1; stall_left = stall_len;
    stalled = 0; first = 1; resume_chk = 0;
    held_d = '0; held_a = '0;
    build_expected();
    @(posedge clk); #1 start = 1'b1; m_tready = 1'b1;
    @(posedge clk); #1 start = 1'b0; start_cyc = cyc;
    for (int t = 0; t < 4000; t++) begin
      if (t > 0) begin @(posedge clk); #1; end
      start = (extra_start_at > 0 && (cyc - start_cyc) == extra_start_at);
      if (m_tvalid && beats == stall_beat && stall_left > 0) begin
        m_tready = 1'b0;
        stall_left--;
      end else if (rand_bp) begin
        m_tready = ($urandom_range(0, 3) != 0);
      end else begin
        m_tready = 1'b1;
      end
      @(negedge clk);
      if (first) begin
        first = 0;
        total++;
        if (busy !== 1'b1) $display("FAIL %s busy_after_start: got %b expected 1", name, busy);
        else passed++;
        total++;
        if (lut_addr !== '0) $display("FAIL %s first_addr: got %h expected 00", name, lut_addr);
        else passed++;
      end
      if (resume_chk) begin
        resume_chk = 0;
        total++;
        if (lut_addr !== IN_BITS'(beats * E))
          $display("FAIL %s resume_addr: got %h expected %h", name, lut_addr, IN_BITS'(beats * E));
        else passed++;
      end
      if (stalled) begin
        total++;
        if (m_tvalid !== 1'b1 || m_tdata !== held_d || lut_addr !== held_a)
          $display("FAIL %s stall_hold: got v=%b d=%h a=%h expected v=1 d=%h a=%h",
                   name, m_tvalid, m_tdata, lut_addr, held_d, held_a);
        else passed++;
      end
      if (m_tvalid) begin
        if (!m_tready) begin
          if (!stalled && beats == stall_beat) begin
            total++;
            if (lut_addr !== IN_BITS'((beats + 1) * E - 1))
              $display("FAIL %s stall_addr: got %h expected %h", name, lut_addr, IN_BITS'((beats + 1) * E - 1));
            else passed++;
          end
          stalled = 1; held_d = m_tdata; held_a = lut_addr;
        end else begin
          if (stalled && beats == stall_beat) resume_chk = 1;
          stalled = 0;
          total++;
          if (beats >= exp_q.size()) begin
            $display("FAIL %s extra_beat: got beat %0d expected at most %0d beats", name, beats, exp_q.size());
          end else if (m_tdata !== exp_q[beats]) begin
            $display("FAIL %s beat%0d_data: got %h expected %h", name, beats, m_tdata, exp_q[beats]);
          end else passed++;
          total++;
          if (m_tlast !== (beats == exp_q.size() - 1))
            $display("FAIL %s beat%0d_last: got %b expected %b", name, beats, m_tlast, (beats == exp_q.size() - 1));
          else passed++;
          beats++;
        end
      end else begin
        stalled = 0;
      end
      if (done) begin
        dur = cyc - start_cyc;
        if (start_on_done) start = 1'b1;
        break;
      end
    end
    total++;
    if (dur < 0) $display("FAIL %s timeout: got no done expected done", name);
    else if (exp_dur >= 0 && dur != exp_dur) $display("FAIL %s duration: got %0d expected %0d", name, dur, exp_dur);
    else passed++;
    total++;
    if (beats != EXP_BEATS) $display("FAIL %s beat_count: got %0d expected %0d", name, beats, EXP_BEATS);
    else passed++;
    total++;
    if (busy !== 1'b0 || lut_addr !== '0)
      $display("FAIL %s done_cycle: got busy=%b addr=%h expected busy=0 addr=00", name, busy, lut_addr);
    else passed++;
    @(posedge clk); #1 start = 1'b0; m_tready = 1'b1;
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || m_tvalid !== 1'b0)
      $display("FAIL %s after_done: got done=%b busy=%b valid=%b expected 0 0 0", name, done, busy, m_tvalid);
    else passed++;
  endtask

  task automatic check_all_zero(input string name);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || m_tvalid !== 1'b0 || m_tlast !== 1'b0 ||
        lut_addr !== '0 || m_tdata !== '0)
      $display("FAIL %s outputs: got busy=%b done=%b v=%b last=%b a=%h d=%h expected all 0",
               name, busy, done, m_tvalid, m_tlast, lut_addr, m_tdata);
    else passed++;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_lat0");
    sel = 1'b1; #1;
    check_all_zero("reset_lat2");
    sel = 1'b0;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_alternating();
    fill_alt();
    run_sweep("alternating", -1, 0, 1'b0, 0, 1'b0, 264 + CS);
  endtask

  task automatic test_single_hit();
    fill_top();
    run_sweep("single_hit", -1, 0, 1'b0, 0, 1'b0, 264 + CS);
  endtask

  task automatic test_backpressure();
    fill_alt();
    run_sweep("stall_beat2", 2, 5, 1'b0, 0, 1'b0, 269 + CS);
  endtask

  task automatic test_latency();
    sel = 1'b1;
    fill_alt();
    run_sweep("latency2", -1, 0, 1'b0, 0, 1'b0, 776 + CS);
    fill_rand();
    run_sweep("latency2_rand", -1, 0, 1'b1, 0, 1'b0, -1);
    sel = 1'b0;
  endtask

  task automatic test_start_while_busy();
    fill_alt();
    run_sweep("start_busy", -1, 0, 1'b0, 50, 1'b0, 264 + CS);
  endtask

  task automatic test_start_on_done();
    fill_rand();
    run_sweep("start_on_done", -1, 0, 1'b0, 0, 1'b1, 264 + CS);
  endtask

  task automatic test_random();
    for (int r = 0; r < 2; r++) begin
      fill_rand();
      run_sweep("random_bp", -1, 0, 1'b1, 0, 1'b0, -1);
    end
  endtask

  task automatic test_reset_mid_sweep();
    bit hit;
    hit = 0;
    fill_alt();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      if (lut_addr == 8'd100) begin hit = 1; break; end
    end
    total++;
    if (!hit) $display("FAIL reset_mid reach_entry100: got %h expected 64", lut_addr);
    else passed++;
    rst = 1'b1;
    #1;
    check_all_zero("reset_mid");
    @(negedge clk) rst = 1'b0;
    fill_rand();
    run_sweep("after_reset", -1, 0, 1'b0, 0, 1'b0, 264 + CS);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; m_tready = 1'b0; sel = 1'b0;
    test_reset();
    test_alternating();
    test_single_hit();
    test_backpressure();
    test_latency();
    test_start_while_busy();
    test_start_on_done();
    test_random();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lut_neuron_readback.md
Name: lut_neuron_readback

Overview:
- Readback engine for a generated LUT neuron, which is a combinational or registered ROM mapping an IN_BITS address to an OUT_BITS result.
- Drives every address from 0 to 2^IN_BITS-1 onto the neuron's input and samples the neuron's output for each one.
- Packs the sampled results into WORD_W-bit words and streams them out on a valid/ready interface.
- Used for on-chip verification of synthesized layer ROMs against the software truth tables; one instance sits beside each neuron under test.

Parameters:
- IN_BITS, 8: neuron address width; the sweep covers 2^IN_BITS entries.
- OUT_BITS, 1: neuron output width.
- WORD_W, 32: width of the output stream word. WORD_W % OUT_BITS must be 0, and (2^IN_BITS*OUT_BITS) % WORD_W must be 0.
- LUT_LATENCY, 0: number of clock cycles from lut_addr to a valid lut_data (0 means a combinational ROM).

Ports:
- clk in 1: single clock.
- rst in 1: asynchronous, active-high reset.
- start in 1: pulse that begins a sweep; sampled only in IDLE.
- busy out 1: high from the cycle after start is accepted until the final beat completes.
- done out 1: one-cycle pulse in the cycle after the last beat handshakes.
- lut_addr out IN_BITS: drives the neuron input M0.
- lut_data in OUT_BITS: neuron output M1.
- m_tdata out WORD_W: packed truth-table word.
- m_tvalid out 1: word valid.
- m_tready in 1: downstream ready.
- m_tlast out 1: marks the final beat.

Behaviour:
- Reset values: all outputs 0, lut_addr 0, FSM in IDLE, entry counter 0, pack register 0.
- Per-entry operation:
  - Each entry holds lut_addr for LUT_LATENCY+1 cycles.
  - lut_data is captured on the last of those cycles.
  - The captured value is written into the pack register at bits [(k % E)*OUT_BITS +: OUT_BITS], where k is the entry index and E = WORD_W/OUT_BITS.
  - Entry order is plain binary increment, LSB entry first within a word.
- FSM states: IDLE, SAMPLE, WAIT, EMIT.
  - IDLE: start=1 → SAMPLE with k=0 and lut_addr=0. busy rises the next cycle.
  - SAMPLE: if LUT_LATENCY>0 → WAIT and load the latency counter. Otherwise capture in this cycle.
  - WAIT: decrement the latency counter; capture when it reaches 0.
  - After capture:
    - If k%E == E-1 → EMIT.
    - Otherwise k+1, lut_addr+1, then → SAMPLE.
  - EMIT: m_tvalid=1 and m_tdata=pack register.
    - m_tdata, m_tlast and lut_addr stay stable while m_tready=0.
    - On handshake: clear the pack register.
    - If this was the last word → IDLE, with busy=0 and a done pulse.
    - Otherwise k+1, lut_addr+1, then → SAMPLE.
- m_tlast=1 only on beat (2^IN_BITS*OUT_BITS/WORD_W)-1.
- No sampling occurs during EMIT; backpressure stalls the sweep entirely.
- m_tvalid, once asserted, never drops without a handshake.
- The last entry's lut_addr = 2^IN_BITS-1. lut_addr wraps to 0 on return to IDLE; there is no overflow into extra bits.
- start while busy: ignored, with no restart and no effect on counters.
- start in the same cycle as done: ignored; a new sweep needs start in IDLE.
- rst mid-sweep: immediately returns to the reset values. A partial word is discarded and m_tvalid drops asynchronously.
- Default-parameter sweep: 256 entries, 8 beats. With LUT_LATENCY=0 and m_tready held at 1, the sweep takes 256 SAMPLE cycles + 8 EMIT cycles = 264 cycles, start to done-1.

Optional Feature:
- Macro: LUT_READBACK_CHECKSUM_EN.
- When defined:
  - An extra beat follows the last data word. Its m_tdata is the XOR of all data words in the sweep.
  - m_tlast moves to the checksum beat; the last data word has m_tlast=0.
  - The checksum accumulator clears on start acceptance and on rst.
  - done pulses after the checksum beat handshakes.
- When undefined: no accumulator logic, no extra beat, and the behaviour is exactly as above.

Test Plan:
- lut_data=lut_addr[0], LUT_LATENCY=0, m_tready=1, start pulse → 8 beats, each 0xAAAAAAAA. m_tlast only on beat 7. done 264 cycles after start.
- lut_data=(lut_addr==8'hFF) → beats 0-6 are 0x00000000 and beat 7 is 0x80000000. With LUT_READBACK_CHECKSUM_EN: a 9th beat 0x80000000 with m_tlast, and beat 7 has m_tlast=0.
- Pattern from scenario 1, m_tready=0 for 5 cycles when beat 2 is first valid → m_tdata=0xAAAAAAAA, m_tvalid=1 and lut_addr=8'h5F stay stable for all 5 cycles. The sweep resumes at 8'h60 after the handshake; total time is 269 cycles.
- LUT_LATENCY=2, the bench model registers lut_data 2 cycles after lut_addr with the scenario 1 pattern → identical 8 beats, each 0xAAAAAAAA, in 256*3+8 = 776 cycles. Proves the capture is aligned to latency.
- Second start pulse at cycle 50 of a sweep → ignored; the beat count remains 8 and no restart occurs.
- rst asserted at entry 100 → all outputs 0 in the same cycle. A following start produces a full, correct 8-beat sweep beginning at lut_addr 0.
